omsp_spm_key_loader: RTL

Sequencer directly upstream of the SPM control array's key-write port. It captures a freshly derived `SECURITY`-bit module key from the key-derivation engine and streams it, one 16-bit word per cycle, onto `write_key` / `key_in` / `key_idx` of the SPM control block. It handles back-pressure (`hold`), cancellation (`abort`) and zeroisation of its internal copy. Completion is signalled to the execution-unit sequencer with `done` or `aborted`.

---
 rtl/omsp_spm_key_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/omsp_spm_key_loader.sv
// ---------------------------------------------------------------------------
// omsp_spm_key_loader
//
// Captures a freshly derived module key and streams it, one 16-bit word per
// cycle, into the key-write port of the SPM control array. Word 0 is the most
// significant word of key_data (bit 0 of key_data is the key MSB).
//
// Ports
//   mclk, puc_rst_n   clock and asynchronous active-low reset
//   start, key_data   load request and key (key valid in the start cycle only)
//   hold              stall: no write, index frozen
//   abort             cancel the transfer in progress (ignored outside WRITE)
//   write_key, key_in, key_idx   word-write interface to the SPM control block
//   busy              high while a transfer is in WRITE or DONE
//   done, aborted     one-cycle completion / cancellation pulses
// ---------------------------------------------------------------------------
module omsp_spm_key_loader #(
    parameter int SECURITY     = 64,
    parameter int KEY_IDX_SIZE = 2
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    start,
    input  logic [0:SECURITY-1]     key_data,
    input  logic                    hold,
    input  logic                    abort,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);

    localparam int N = SECURITY / 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [N-1:0][15:0]        key_buf_q, key_buf_d;
    logic [KEY_IDX_SIZE-1:0]   cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      aborted_q, aborted_d;

    logic in_write;
    logic wr;
    logic last_word;

    assign in_write  = (state_q == ST_WRITE);
    // abort has priority over hold: neither writes, but abort also cancels
    assign wr        = in_write & ~hold & ~abort;
    assign last_word = (cnt_q == KEY_IDX_SIZE'(N - 1));

    always_comb begin
        state_d   = state_q;
        key_buf_d = key_buf_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        key_buf_d[i] = key_data[i*16 +: 16];
                    end
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    key_buf_d = '0;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (!hold) begin
                    if (last_word) begin
                        // counter stays put; it is cleared in DONE
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // key fully written: return to IDLE regardless of abort
                state_d   = ST_IDLE;
                key_buf_d = '0;
                cnt_d     = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                key_buf_d = '0;
                cnt_d     = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q   <= ST_IDLE;
            key_buf_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_buf_q <= key_buf_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Key material is only driven out while in WRITE
    assign write_key = wr;
    assign key_in    = in_write ? key_buf_q[cnt_q] : 16'h0000;
    assign key_idx   = in_write ? cnt_q : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
